// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the multiplexed 7-segment scan decoder:
// FSM state encoding, active-low segment patterns for hex digits 0-F,
// the decimal-point bit position and a small one-hot helper.
package seg_scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } scan_state_t;

    // Decimal point position inside the 8-bit cathode bus
    localparam int DP_BIT = 7;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    // True when exactly one bit of a 4-bit vector is set
    function automatic logic is_one_hot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// Combinational decode of one active-low 7-segment pattern to its hex
// nibble. Patterns outside the 16-entry table give nibble 0, valid 0.
module seg7_to_hex
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       valid
);

    // Table lookup of the segment pattern
    always_comb begin
        nibble = 4'h0;
        valid  = 1'b1;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: begin
                nibble = 4'h0;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receiving end of a 4-digit multiplexed 7-segment scan. Samples the
// cathode and anode lines, waits for each digit to be stable, decodes it
// into a shadow slot and publishes a full frame once all four digits have
// been seen. Flags bad anode patterns (sticky) and a missing-frame timeout.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  cathodes,
    input  logic [3:0]  AN,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        an_err,
    output logic        stale
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    logic [3:0]    an_r;
    logic [7:0]    cath_r;
    logic [3:0]    an_prev_r;
    logic [7:0]    cath_prev_r;
    logic [SW-1:0] settle_cnt_r;
    scan_state_t   state_r;

    logic [3:0]    dec_nib_s;
    logic          dec_ok_s;

    logic          changed_s;
    logic          capture_s;
    logic          frame_done_s;
    logic          an_bad_s;
    logic [3:0]    wr_mask_s;
    logic [3:0]    seen_r;
    logic [3:0]    bad_r;
    logic [3:0]    seen_next_s;
    logic [3:0]    bad_next_s;
    logic [3:0]    shadow_nib_r [4];
    logic [3:0]    shadow_dp_r;

    logic [TW-1:0] tmo_cnt_r;
    logic [TW-1:0] tmo_next_s;

    seg7_to_hex u_dec (
        .seg    (cath_r[6:0]),
        .nibble (dec_nib_s),
        .valid  (dec_ok_s)
    );

    // Register the raw scan lines once, and keep the previous registered copy for change detection
    always_ff @(posedge sysclk) begin
        if (reset) begin
            an_r        <= 4'hF;
            cath_r      <= 8'hFF;
            an_prev_r   <= 4'hF;
            cath_prev_r <= 8'hFF;
        end else begin
            an_r        <= AN;
            cath_r      <= cathodes;
            an_prev_r   <= an_r;
            cath_prev_r <= cath_r;
        end
    end

    // Capture qualification, slot write mask and next seen/bad bits
    always_comb begin
        changed_s    = ({an_r, cath_r} != {an_prev_r, cath_prev_r});
        frame_done_s = (seen_r == 4'b1111);
        seen_next_s  = seen_r;
        bad_next_s   = bad_r;
        // A change during the capture cycle means the sampled value is not the settled one
        if ((state_r == ST_CAPTURE) && !changed_s) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        if (capture_s && is_one_hot4(~an_r)) begin
            wr_mask_s = ~an_r;
        end else begin
            wr_mask_s = 4'b0000;
        end
        if (capture_s && (an_r != 4'b1111) && !is_one_hot4(~an_r)) begin
            an_bad_s = 1'b1;
        end else begin
            an_bad_s = 1'b0;
        end
        // A capture coinciding with the frame copy lands in the freshly cleared set
        for (int i = 0; i < 4; i++) begin
            if (wr_mask_s[i]) begin
                seen_next_s[i] = 1'b1;
                bad_next_s[i]  = !dec_ok_s;
            end else if (frame_done_s) begin
                seen_next_s[i] = 1'b0;
                bad_next_s[i]  = 1'b0;
            end else begin
                seen_next_s[i] = seen_r[i];
                bad_next_s[i]  = bad_r[i];
            end
        end
    end

    // Stability counter: restarts on any line change, saturates at the settle length
    always_ff @(posedge sysclk) begin
        if (reset) begin
            settle_cnt_r <= '0;
        end else if (changed_s) begin
            settle_cnt_r <= '0;
        end else if (settle_cnt_r != SETTLE_MAX) begin
            settle_cnt_r <= settle_cnt_r + SW'(1);
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    // Scan FSM: wait for a change, wait for it to settle, capture once
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (changed_s) begin
                        state_r <= ST_SETTLE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (!changed_s && (settle_cnt_r == SETTLE_MAX)) begin
                        state_r <= ST_CAPTURE;
                    end else begin
                        state_r <= ST_SETTLE;
                    end
                end
                ST_CAPTURE: begin
                    // A fresh change here still needs its own settle period
                    if (changed_s) begin
                        state_r <= ST_SETTLE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Shadow slots and their seen/bad bookkeeping
    always_ff @(posedge sysclk) begin
        if (reset) begin
            seen_r      <= 4'b0000;
            bad_r       <= 4'b0000;
            shadow_dp_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                shadow_nib_r[i] <= 4'h0;
            end
        end else begin
            seen_r <= seen_next_s;
            bad_r  <= bad_next_s;
            for (int i = 0; i < 4; i++) begin
                if (wr_mask_s[i]) begin
                    shadow_nib_r[i] <= dec_nib_s;
                    shadow_dp_r[i]  <= !cath_r[DP_BIT];
                end else begin
                    shadow_nib_r[i] <= shadow_nib_r[i];
                    shadow_dp_r[i]  <= shadow_dp_r[i];
                end
            end
        end
    end

    // Publish a complete frame the cycle after the last slot is seen
    always_ff @(posedge sysclk) begin
        if (reset) begin
            digits      <= 16'h0000;
            dp          <= 4'b0000;
            seg_err     <= 1'b0;
            frame_valid <= 1'b0;
        end else if (frame_done_s) begin
            digits      <= {shadow_nib_r[3], shadow_nib_r[2], shadow_nib_r[1], shadow_nib_r[0]};
            dp          <= shadow_dp_r;
            seg_err     <= |bad_r;
            frame_valid <= 1'b1;
        end else begin
            frame_valid <= 1'b0;
        end
    end

    // Sticky flag for a settled anode pattern that selects several digits
    always_ff @(posedge sysclk) begin
        if (reset) begin
            an_err <= 1'b0;
        end else if (an_bad_s) begin
            an_err <= 1'b1;
        end else begin
            an_err <= an_err;
        end
    end

    // Next value of the frame timeout counter
    always_comb begin
        if (frame_valid) begin
            tmo_next_s = '0;
        end else if (tmo_cnt_r != TIMEOUT_MAX) begin
            tmo_next_s = tmo_cnt_r + TW'(1);
        end else begin
            tmo_next_s = tmo_cnt_r;
        end
    end

    // Frame timeout counter and its registered stale indication
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tmo_cnt_r <= '0;
            stale     <= 1'b0;
        end else begin
            tmo_cnt_r <= tmo_next_s;
            stale     <= (tmo_next_s == TIMEOUT_MAX);
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scans plus random
// digit dwells, compared against a dwell-level reference model.
module tb_seg_scan_decoder;

    localparam int SETTLE   = 4;
    localparam int TMO      = 1000;
    localparam int LONG_MIN = SETTLE + 6;   // dwell certainly long enough to be captured
    localparam int CHK_MIN  = LONG_MIN + 2; // dwell long enough for the frame to be out too

    logic        sysclk = 1'b0;
    logic        reset;
    logic [7:0]  cathodes;
    logic [3:0]  an_in;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        seg_err;
    logic        an_err;
    logic        stale;

    seg_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .cathodes    (cathodes),
        .AN          (an_in),
        .digits      (digits),
        .dp          (dp),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .an_err      (an_err),
        .stale       (stale)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  p;
        logic        e;
    } frame_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [6:0]  seg_tab [16];
    logic [3:0]  m_nib   [4];
    logic [3:0]  m_dp;
    logic [3:0]  m_seen;
    logic [3:0]  m_bad;
    logic        m_an_err;
    logic [15:0] m_digits;
    logic [3:0]  m_dpo;
    logic        m_seg_err;
    frame_t      exp_q [$];
    int          cyc_since;
    logic [3:0]  last_an;
    logic [7:0]  last_cath;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input int n, input logic dp_on);
        return {~dp_on, seg_tab[n]};
    endfunction

    // Dwell-level model: a long enough stable dwell is one captured digit
    task automatic model_dwell(input logic [3:0] an, input logic [7:0] cath, input int len);
        int     idx;
        logic   ok;
        logic [3:0] nib;
        frame_t f;
        if (len >= LONG_MIN) begin
            if (an == 4'b1111) begin
                idx = 0;
            end else if ($countones(~an) == 1) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
                ok  = 1'b0;
                nib = 4'h0;
                for (int k = 0; k < 16; k++) begin
                    if (cath[6:0] == seg_tab[k]) begin
                        ok  = 1'b1;
                        nib = 4'(k);
                    end
                end
                m_nib[idx]  = nib;
                m_dp[idx]   = ~cath[7];
                m_bad[idx]  = ~ok;
                m_seen[idx] = 1'b1;
                if (m_seen == 4'b1111) begin
                    f.d = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                    f.p = m_dp;
                    f.e = |m_bad;
                    exp_q.push_back(f);
                    m_digits  = f.d;
                    m_dpo     = f.p;
                    m_seg_err = f.e;
                    m_seen    = 4'b0000;
                    m_bad     = 4'b0000;
                end
            end else begin
                m_an_err = 1'b1;
            end
        end
    endtask

    // One clock: sample outputs on the falling edge and score any frame
    task automatic tick();
        frame_t f;
        @(negedge sysclk);
        cyc_since++;
        if (frame_valid === 1'b1) begin
            cyc_since = 0;
            chk_eq("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                f = exp_q.pop_front();
                chk_eq("frame_digits", 32'(digits), 32'(f.d));
                chk_eq("frame_dp", 32'(dp), 32'(f.p));
                chk_eq("frame_seg_err", 32'(seg_err), 32'(f.e));
            end
        end
    endtask

    task automatic show(input logic [3:0] an, input logic [7:0] cath, input int len);
        model_dwell(an, cath, len);
        an_in     = an;
        cathodes  = cath;
        last_an   = an;
        last_cath = cath;
        repeat (len) tick();
        chk_eq("an_err", 32'(an_err), 32'(m_an_err));
        if (len >= CHK_MIN) begin
            chk_eq("digits_hold", 32'(digits), 32'(m_digits));
            chk_eq("dp_hold", 32'(dp), 32'(m_dpo));
            chk_eq("seg_err_hold", 32'(seg_err), 32'(m_seg_err));
        end
        if (cyc_since < TMO - 5) chk_eq("stale_low", 32'(stale), 32'd0);
        else if (cyc_since > TMO + 5) chk_eq("stale_high", 32'(stale), 32'd1);
    endtask

    task automatic sweep(input logic [15:0] val, input logic [3:0] dps, input int len);
        for (int i = 0; i < 4; i++) show(4'(~(4'b0001 << i)), glyph(int'(val[4*i +: 4]), dps[i]), len);
    endtask

    task automatic do_reset();
        an_in    = 4'hF;
        cathodes = 8'hFF;
        reset    = 1'b1;
        repeat (3) tick();
        chk_eq("rst_digits", 32'(digits), 32'd0);
        chk_eq("rst_dp", 32'(dp), 32'd0);
        chk_eq("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk_eq("rst_seg_err", 32'(seg_err), 32'd0);
        chk_eq("rst_an_err", 32'(an_err), 32'd0);
        chk_eq("rst_stale", 32'(stale), 32'd0);
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_dp      = 4'b0000;
        m_seen    = 4'b0000;
        m_bad     = 4'b0000;
        m_an_err  = 1'b0;
        m_digits  = 16'h0000;
        m_dpo     = 4'b0000;
        m_seg_err = 1'b0;
        exp_q.delete();
        last_an   = 4'hF;
        last_cath = 8'hFF;
        reset     = 1'b0;
        cyc_since = 0;
    endtask

    initial begin
        logic [3:0] an;
        logic [7:0] cath;
        int         len;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        cyc_since = 0;
        do_reset();

        // "1234", two sweeps at 1000 cycles per digit
        sweep(16'h1234, 4'b0000, 1000);
        sweep(16'h1234, 4'b0000, 1000);

        // "AbCd" with the decimal point on AN[2]
        sweep(16'hABCD, 4'b0100, 200);

        // Blank segments on AN[1] give nibble 0 and a segment error
        show(4'b1110, glyph(5, 1'b0), 60);
        show(4'b1101, 8'hFF, 60);
        show(4'b1011, glyph(14, 1'b0), 60);
        show(4'b0111, glyph(9, 1'b1), 60);

        // Random dwells: hex or arbitrary patterns, blanking, short glitches
        for (int n = 0; n < 300; n++) begin
            do begin
                if ($urandom_range(0, 9) == 0) an = 4'hF;
                else an = 4'(~(4'b0001 << $urandom_range(0, 3)));
                if ($urandom_range(0, 6) == 0) cath[6:0] = 7'($urandom);
                else cath[6:0] = seg_tab[$urandom_range(0, 15)];
                cath[7] = 1'($urandom);
            end while ({an, cath} == {last_an, last_cath});
            if ($urandom_range(0, 3) == 0) len = int'($urandom_range(1, SETTLE - 1));
            else len = int'($urandom_range(CHK_MIN, 40));
            show(an, cath, len);
        end

        // Two digits enabled at once for 10 cycles: sticky anode error, frame untouched
        show(4'b1100, glyph(3, 1'b0), 10);
        show(4'b1111, 8'hFF, 40);
        show(4'b1110, glyph(1, 1'b0), 30);

        // Digits changing every 3 cycles never settle, so the frame goes stale
        for (int n = 0; n < 380; n++) show(4'(~(4'b0001 << (n % 4))), glyph(n % 16, 1'b0), 3);
        show(4'b1111, 8'hFF, 20);

        // Reset with two slots captured, then a clean "5678"
        do_reset();
        show(4'b1011, glyph(14, 1'b0), 30);
        show(4'b0111, glyph(9, 1'b0), 30);
        do_reset();
        sweep(16'h5678, 4'b0000, 40);
        sweep(16'h5678, 4'b0001, 40);
        show(4'b1111, 8'hFF, 20);

        chk_eq("frames_pending", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
